// File: rtl/seq_mult_ctrl_if.sv
// Handshake and operand/product bundle for the sequential shift-add multiplier.
interface seq_mult_ctrl_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               is_signed;
  logic [WIDTH-1:0]   opA;
  logic [WIDTH-1:0]   opB;
  logic               in_ready;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, is_signed, opA, opB,
    input  in_ready, busy, done, product
  );

  modport slave (
    input  start, is_signed, opA, opB,
    output in_ready, busy, done, product
  );
endinterface

// File: rtl/seq_mult_ctrl.sv
// Iterative radix-2 shift-add multiplier control and datapath for the FPU mantissa path.
// Optional early termination when the remaining multiplier bits are zero: SEQ_MULT_EARLY_TERM_EN.
module seq_mult_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  seq_mult_ctrl_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [2*WIDTH-1:0] r_mA;
  logic [WIDTH:0]     r_mB;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_neg;
  logic [2*WIDTH-1:0] r_product;

  logic               w_accept;
  logic               w_lastIter;
  logic [WIDTH:0]     w_extA;
  logic [WIDTH:0]     w_extB;
  logic [WIDTH:0]     w_absA;
  logic [WIDTH:0]     w_absB;
  logic [2*WIDTH-1:0] w_accNext;
  logic [WIDTH:0]     w_mBNext;
  logic               w_inReady;
  logic               w_busy;
  logic               w_done;

  // Magnitudes use one extra bit so that the most negative operand stays exact.
  assign w_extA = {bus.opA[WIDTH-1] & bus.is_signed, bus.opA};
  assign w_extB = {bus.opB[WIDTH-1] & bus.is_signed, bus.opB};
  assign w_absA = w_extA[WIDTH] ? (~w_extA + 1'b1) : w_extA;
  assign w_absB = w_extB[WIDTH] ? (~w_extB + 1'b1) : w_extB;

  assign w_accept  = (r_state == IDLE) && bus.start;
  assign w_accNext = r_mB[0] ? (r_acc + r_mA) : r_acc;
  assign w_mBNext  = r_mB >> 1;

`ifdef SEQ_MULT_EARLY_TERM_EN
  assign w_lastIter = (r_cnt == LAST_CNT) || (w_mBNext == '0);
`else
  assign w_lastIter = (r_cnt == LAST_CNT);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_inReady   = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        w_inReady = 1'b1;
        if (bus.start) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        w_busy = 1'b1;
        if (w_lastIter) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // The product register is written only on the final RUN edge, so it holds through done and IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mA      <= '0;
      r_mB      <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_product <= '0;
    end else if (w_accept) begin
      r_mA  <= {{(WIDTH-1){1'b0}}, w_absA};
      r_mB  <= w_absB;
      r_acc <= '0;
      r_cnt <= '0;
      r_neg <= bus.is_signed & (bus.opA[WIDTH-1] ^ bus.opB[WIDTH-1]);
    end else if (r_state == RUN) begin
      r_acc <= w_accNext;
      r_mA  <= r_mA << 1;
      r_mB  <= w_mBNext;
      r_cnt <= r_cnt + 1'b1;
      if (w_lastIter) begin
        r_product <= r_neg ? (~w_accNext + 1'b1) : w_accNext;
      end
    end
  end

  assign bus.in_ready = w_inReady;
  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.product  = r_product;
endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed self-checking bench for seq_mult_ctrl: products, latency, ignored start and mid-run reset.
module tb_seq_mult_ctrl;
  localparam int WIDTH = 32;

  logic clk;
  logic reset;
  int   checksRun;
  int   checksPassed;

  seq_mult_ctrl_if #(.WIDTH(WIDTH)) bus ();

  seq_mult_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checksRun++;
    if (observed === expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, observed, expected);
    end
  endtask

  // Number of RUN cycles expected between accept and done.
  function automatic int expLatency(input logic [31:0] b, input logic s);
`ifdef SEQ_MULT_EARLY_TERM_EN
    logic [32:0] m;
    int hi;
    m  = (s && b[31]) ? (~{1'b1, b} + 33'd1) : {1'b0, b};
    hi = 0;
    for (int i = 0; i < 33; i++) begin
      if (m[i]) hi = i;
    end
    return hi + 1;
`else
    return WIDTH;
`endif
  endfunction

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s,
                               input logic [63:0] expProd, input string tag,
                               input int strayAt, input int abortAt);
    int   cycles;
    logic gotDone;
    logic sawBad;
    logic sawDone;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.opA       = a;
    bus.opB       = b;
    bus.is_signed = s;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.opA       = 32'hDEAD_BEEF;
    bus.opB       = 32'h0BAD_F00D;
    bus.is_signed = ~s;
    cycles  = 0;
    gotDone = 1'b0;
    sawBad  = 1'b0;
    while (!gotDone && cycles < 200) begin
      if (bus.in_ready || !bus.busy || bus.done) sawBad = 1'b1;
      if (abortAt >= 0 && cycles == abortAt) begin
        #2;
        reset = 1'b1;
        #1;
        checkOutput({tag, " abort in_ready"}, 64'(bus.in_ready), 64'd1);
        checkOutput({tag, " abort busy"},     64'(bus.busy),     64'd0);
        checkOutput({tag, " abort done"},     64'(bus.done),     64'd0);
        checkOutput({tag, " abort product"},  bus.product,       64'd0);
        sawDone = 1'b0;
        repeat (3) begin
          @(posedge clk);
          #1;
          if (bus.done) sawDone = 1'b1;
        end
        checkOutput({tag, " abort no done"}, 64'(sawDone), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (strayAt >= 0 && cycles == strayAt) begin
        bus.start     = 1'b1;
        bus.opA       = 32'hFFFF_FFFF;
        bus.opB       = 32'hFFFF_FFFF;
        bus.is_signed = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      cycles++;
      if (bus.done) gotDone = 1'b1;
    end
    bus.start = 1'b0;
    checkOutput({tag, " done seen"}, 64'(gotDone), 64'd1);
    checkOutput({tag, " latency"},   64'(cycles),  64'(expLatency(b, s)));
    checkOutput({tag, " product"},   bus.product,  expProd);
    checkOutput({tag, " busy while running"}, 64'(sawBad), 64'd0);
    @(posedge clk);
    #1;
    checkOutput({tag, " done pulse width"}, 64'(bus.done),     64'd0);
    checkOutput({tag, " back to idle"},     64'(bus.in_ready), 64'd1);
    checkOutput({tag, " product held"},     bus.product,       expProd);
  endtask

  initial begin
    checksRun     = 0;
    checksPassed  = 0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.opA       = '0;
    bus.opB       = '0;
    #3;
    checkOutput("reset in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("reset busy",     64'(bus.busy),     64'd0);
    checkOutput("reset done",     64'(bus.done),     64'd0);
    checkOutput("reset product",  bus.product,       64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(32'd3,          32'd5,          1'b0, 64'h0000_0000_0000_000F, "u 3x5",        -1, -1);
    applyStimulus(32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 64'hFFFF_FFFE_0000_0001, "u max*max",    -1, -1);
    applyStimulus(32'hFFFF_FFF9,  32'd3,          1'b1, 64'hFFFF_FFFF_FFFF_FFEB, "s -7x3",       -1, -1);
    applyStimulus(32'h8000_0000,  32'h8000_0000,  1'b1, 64'h4000_0000_0000_0000, "s min*min",    -1, -1);
    applyStimulus(32'd5,          32'hFFFF_FFFC,  1'b1, 64'hFFFF_FFFF_FFFF_FFEC, "s 5x-4",       -1, -1);
    applyStimulus(32'h1234_5678,  32'd0,          1'b1, 64'h0000_0000_0000_0000, "zero opB",     -1, -1);
    applyStimulus(32'h8000_0000,  32'd2,          1'b0, 64'h0000_0001_0000_0000, "u 2^31x2",     -1, -1);
    applyStimulus(32'd7,          32'd1,          1'b0, 64'h0000_0000_0000_0007, "u 7x1",        -1, -1);
    applyStimulus(32'd3,          32'h8000_0001,  1'b0, 64'h0000_0001_8000_0003, "stray start",  10, -1);
    applyStimulus(32'd9,          32'h8000_0000,  1'b0, 64'h0,                   "abort",        -1, 17);
    applyStimulus(32'd2,          32'd2,          1'b0, 64'h0000_0000_0000_0004, "post-reset 2x2", -1, -1);

    $display("%0d/%0d checks passed", checksPassed, checksRun);
    $finish;
  end
endmodule
